// File: rtl/latch_bank_ctrl.sv
// Bank of CHANNELS storage elements loaded from a shared data bus. A small FSM opens
// one channel for a programmed number of cycles; MODE picks latch or close-edge flop storage.
module latch_bank_ctrl #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int LEN_W    = 4,
  parameter int MODE     = 0,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [CH_W-1:0]           req_ch,
  input  logic [LEN_W-1:0]          req_len,
  input  logic [WIDTH-1:0]          d,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       en,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    CLOSE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [CHANNELS-1:0] en_q, en_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q;
  logic                req_ready_q;
  logic [CHANNELS-1:0] sel_s;
  logic                reject_s;
  logic                close_s;

  // Decode the requested channel; out-of-range indices select nothing and are rejected.
  always_comb begin
    sel_s = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      sel_s[i] = ({1'b0, req_ch} == (CH_W+1)'(i));
    end
    reject_s = ({1'b0, req_ch} >= (CH_W+1)'(CHANNELS)) || (req_len == {LEN_W{1'b0}});
    close_s  = (state_q == OPEN) && (cnt_q == LEN_W'(1));
  end

  // Next-state logic: accept in IDLE, count down in OPEN, one-cycle CLOSE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (reject_s) begin
            state_d = CLOSE;
            cnt_d   = {LEN_W{1'b0}};
            en_d    = {CHANNELS{1'b0}};
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = OPEN;
            cnt_d   = req_len;
            en_d    = sel_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      OPEN: begin
        if (close_s) begin
          state_d = CLOSE;
          cnt_d   = {LEN_W{1'b0}};
          en_d    = {CHANNELS{1'b0}};
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q - LEN_W'(1);
        end
      end
      CLOSE: begin
        state_d = IDLE;
        en_d    = {CHANNELS{1'b0}};
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {LEN_W{1'b0}};
        en_d    = {CHANNELS{1'b0}};
      end
    endcase
  end

  // Controller state and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {LEN_W{1'b0}};
      en_q        <= {CHANNELS{1'b0}};
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= (state_d != IDLE);
      req_ready_q <= (state_d == IDLE);
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign en        = en_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    if (MODE == 0) begin : g_lat
      logic [WIDTH-1:0] lat_q;
      // Transparent while the channel strobe is high; reset has priority over the enable.
      always_latch begin
        if (rst) begin
          lat_q <= {WIDTH{1'b0}};
        end else if (en_q[g]) begin
          lat_q <= d;
        end
      end
      assign q[g*WIDTH +: WIDTH] = lat_q;
    end else begin : g_flop
      logic [WIDTH-1:0] cap_q;
      // Capture only at the edge that ends this channel's window.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cap_q <= {WIDTH{1'b0}};
        end else if (close_s && en_q[g]) begin
          cap_q <= d;
        end else begin
          cap_q <= cap_q;
        end
      end
      assign q[g*WIDTH +: WIDTH] = cap_q;
    end
  end

endmodule
